uparc_radix2_idiv: RTL and testbench



---
 rtl/uparc_radix2_idiv_pkg.sv | 14 +
 rtl/uparc_radix2_idiv.sv | 141 ++++++++++++++
 tb/tb_uparc_radix2_idiv.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/uparc_radix2_idiv_pkg.sv
// Shared constants for the radix-2 divider: register width and FSM state encoding.
package uparc_radix2_idiv_pkg;

    // Architectural register width of the core.
    localparam int UPARC_REG_WIDTH = 32;

    // Divider control states (2-bit encoding).
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_FIX  = 2'd2
    } div_state_e;

endpackage : uparc_radix2_idiv_pkg

// File: rtl/uparc_radix2_idiv.sv
// Sequential radix-2 restoring integer divider for DIV/DIVU.
// Divides operand magnitudes over WIDTH busy cycles, then applies the sign fix
// in one extra cycle. Result is {remainder, quotient} for HI/LO.
module uparc_radix2_idiv
    import uparc_radix2_idiv_pkg::*;
#(
    parameter int WIDTH = UPARC_REG_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divider,
    input  logic               start,
    input  logic               signd,
    output logic               ready,
    output logic [2*WIDTH-1:0] remquot
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    // Conditional two's-complement negate.
    function automatic logic [WIDTH-1:0] uparc_cneg(input logic [WIDTH-1:0] v, input logic neg);
        logic [WIDTH-1:0] res;
        if (neg) begin
            res = (~v) + WIDTH'(1'b1);
        end else begin
            res = v;
        end
        return res;
    endfunction

    div_state_e         state;
    div_state_e         state_nxt;
    logic [CNT_W-1:0]   cnt;
    // Partial remainder; the top bit stays zero because P < |divider| after each restore.
    logic [WIDTH:0]     p_reg;
    logic [WIDTH-1:0]   q_reg;
    logic [WIDTH-1:0]   dvs;
    logic               neg_q;
    logic               neg_r;
    logic [2*WIDTH-1:0] remquot_reg;

    logic               accept;
    logic [WIDTH+1:0]   shifted;
    logic [WIDTH+1:0]   trial;
    logic               fits;

    assign accept  = (state == DIV_IDLE) && start;
    // {P,Q} shifted left by one, with one guard bit so the trial sign is visible.
    assign shifted = {p_reg, q_reg[WIDTH-1]};
    assign trial   = shifted - {2'b00, dvs};
    assign fits    = ~trial[WIDTH+1];
    assign remquot = remquot_reg;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic: IDLE -> BUSY on start, BUSY until the counter hits zero, one FIX cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            DIV_IDLE: begin
                if (accept) begin
                    state_nxt = DIV_BUSY;
                end else begin
                    state_nxt = DIV_IDLE;
                end
            end
            DIV_BUSY: begin
                if (cnt == CNT_ZERO) begin
                    state_nxt = DIV_FIX;
                end else begin
                    state_nxt = DIV_BUSY;
                end
            end
            DIV_FIX: state_nxt = DIV_IDLE;
            default: state_nxt = DIV_IDLE;
        endcase
    end

    // FSM output: ready drops in the same cycle start is raised so the parent never sees a false idle.
    always_comb begin
        if ((state == DIV_IDLE) && !start) begin
            ready = 1'b1;
        end else begin
            ready = 1'b0;
        end
    end

    // Datapath: operand capture, one restoring step per busy cycle, sign fix into the result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= CNT_ZERO;
            p_reg       <= {(WIDTH+1){1'b0}};
            q_reg       <= {WIDTH{1'b0}};
            dvs         <= {WIDTH{1'b0}};
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            remquot_reg <= {(2*WIDTH){1'b0}};
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (accept) begin
                        cnt   <= CNT_LAST;
                        p_reg <= {(WIDTH+1){1'b0}};
                        q_reg <= uparc_cneg(dividend, signd & dividend[WIDTH-1]);
                        dvs   <= uparc_cneg(divider, signd & divider[WIDTH-1]);
                        neg_q <= signd & (dividend[WIDTH-1] ^ divider[WIDTH-1]);
                        neg_r <= signd & dividend[WIDTH-1];
                    end else begin
                        cnt <= cnt;
                    end
                end
                DIV_BUSY: begin
                    cnt <= cnt - CNT_W'(1'b1);
                    if (fits) begin
                        p_reg <= trial[WIDTH:0];
                    end else begin
                        p_reg <= shifted[WIDTH:0];
                    end
                    q_reg <= {q_reg[WIDTH-2:0], fits};
                end
                DIV_FIX: begin
                    remquot_reg <= {uparc_cneg(p_reg[WIDTH-1:0], neg_r), uparc_cneg(q_reg, neg_q)};
                end
                default: begin
                    cnt <= CNT_ZERO;
                end
            endcase
        end
    end

endmodule : uparc_radix2_idiv

// File: tb/tb_uparc_radix2_idiv.sv
// Self-checking bench for uparc_radix2_idiv: directed corner cases plus random
// operands checked against an arithmetic reference model.
module tb_uparc_radix2_idiv;

    logic        clk;
    logic        rst;
    logic [31:0] dividend;
    logic [31:0] divider;
    logic        start;
    logic        signd;
    logic        ready;
    logic [63:0] remquot;

    int checks = 0;
    int errors = 0;
    int lat;

    uparc_radix2_idiv #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .dividend (dividend),
        .divider  (divider),
        .start    (start),
        .signd    (signd),
        .ready    (ready),
        .remquot  (remquot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: MIPS DIV/DIVU semantics, with divide-by-zero defined by the restoring algorithm.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] q;
        logic [31:0] r;
        longint sa;
        longint sb;
        longint lq;
        longint lr;
        if (!s) begin
            if (b == 32'd0) begin
                q = 32'hFFFF_FFFF;
                r = a;
            end else begin
                q = a / b;
                r = a % b;
            end
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            if (sb == 64'sd0) begin
                q = (sa >= 64'sd0) ? 32'hFFFF_FFFF : 32'h0000_0001;
                r = a;
            end else begin
                lq = sa / sb;
                lr = sa % sb;
                q = lq[31:0];
                r = lr[31:0];
            end
        end
        return {r, q};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Call at a negedge: present operands with start, confirm ready drops combinationally.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        dividend = a;
        divider  = b;
        signd    = s;
        start    = 1'b1;
        #1;
        check("ready_drop_on_start", {63'd0, ready}, 64'd0);
        lat = 1;
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom;
        divider  = $urandom;
        signd    = 1'($urandom_range(0, 1));
        if (!ready) lat++;
    endtask

    // Wait (bounded) for ready, then check latency and result.
    task automatic wait_done(input string tag, input logic [63:0] exp);
        while (!ready && lat < 100) begin
            @(negedge clk);
            if (!ready) lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd34);
        check({tag, "_result"}, remquot, exp);
    endtask

    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        check({tag, "_ready_before"}, {63'd0, ready}, 64'd1);
        issue(a, b, s);
        wait_done(tag, ref_div(a, b, s));
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        logic [63:0] prev;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = 32'd0;
        divider  = 32'd0;
        signd    = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_ready", {63'd0, ready}, 64'd1);
        check("reset_remquot", remquot, 64'd0);
        rst = 1'b0;

        // Directed cases with hand-derived expectations.
        @(negedge clk);
        issue(32'd100, 32'd7, 1'b0);
        wait_done("u100_7", {32'h0000_0002, 32'h0000_000E});
        run_div("s_m7_2", 32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
        check("s_m7_2_abs", remquot, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_div("s_7_m2", 32'h0000_0007, 32'hFFFF_FFFE, 1'b1);
        check("s_7_m2_abs", remquot, {32'h0000_0001, 32'hFFFF_FFFD});
        run_div("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        check("s_ovf_abs", remquot, {32'h0000_0000, 32'h8000_0000});
        run_div("u_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("u_ovf_abs", remquot, {32'h8000_0000, 32'h0000_0000});
        run_div("u_div0", 32'd5, 32'd0, 1'b0);
        check("u_div0_abs", remquot, {32'h0000_0005, 32'hFFFF_FFFF});
        run_div("s_div0", 32'hFFFF_FFFB, 32'd0, 1'b1);
        check("s_div0_abs", remquot, {32'hFFFF_FFFB, 32'h0000_0001});

        // Start during busy cycle 10 must be ignored; stale result must hold while busy.
        prev = remquot;
        @(negedge clk);
        issue(32'd1000, 32'd33, 1'b0);
        while (lat < 10) begin
            @(negedge clk);
            if (!ready) lat++;
        end
        dividend = 32'd77;
        divider  = 32'd5;
        signd    = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (!ready) lat++;
        check("stale_remquot_busy", remquot, prev);
        wait_done("ignored_start", {32'd10, 32'd30});

        // Back-to-back: start in the first ready cycle.
        issue(32'd12345, 32'd100, 1'b0);
        wait_done("b2b", {32'd45, 32'd123});

        // Reset at busy cycle 20 kills the operation immediately.
        @(negedge clk);
        issue(32'd999, 32'd9, 1'b0);
        while (lat < 20) begin
            @(negedge clk);
            if (!ready) lat++;
        end
        rst = 1'b1;
        #1;
        check("midrst_ready", {63'd0, ready}, 64'd1);
        check("midrst_remquot", remquot, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_div("after_rst_9_3", 32'd9, 32'd3, 1'b0);
        check("after_rst_9_3_abs", remquot, {32'd0, 32'd3});

        // Randomized operands, biased toward corner values.
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 5))
                0: ra = 32'h8000_0000;
                1: ra = 32'hFFFF_FFFF;
                2: ra = 32'($urandom_range(0, 20));
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 20));
                3: rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            rs = 1'($urandom_range(0, 1));
            run_div("random", ra, rb, rs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uparc_radix2_idiv
